// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
//   Parametrised inter-stage pipeline register with a valid/ready handshake,
//   flush-to-bubble and an optional 2-entry skid buffer.
//
//   Parameters
//     DATA_W    payload width
//     SKID      1: MAIN + SKID entries, in_ready comes straight from a flop
//               0: single entry, in_ready is combinational from out_ready
//     NOP_DATA  value on out_data whenever out_valid=0
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous reset, active high
//     flush      squash all held entries (next cycle empty)
//     in_valid   upstream payload valid
//     in_ready   stage can accept this cycle
//     in_data    upstream payload
//     out_valid  downstream payload valid
//     out_ready  downstream accepts (0 = stall)
//     out_data   registered payload, NOP_DATA when out_valid=0
//     count      entries held (0..2)
module pipe_stage_skid_reg #(
  parameter int                DATA_W   = 64,
  parameter bit                SKID     = 1'b1,
  parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [1:0]        cnt;

  logic              nxt_mv, nxt_sv;
  logic [DATA_W-1:0] nxt_md, nxt_sd;
  logic              in_fire, out_fire;

  // With the skid buffer, upstream only sees a flop (no path from out_ready).
  // Without it, a held entry leaving this cycle frees the slot immediately.
  always_comb begin
    if (SKID) in_ready = ~skid_valid & ~rst;
    else      in_ready = (~main_valid | out_ready) & ~rst;
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  always_comb begin
    nxt_mv = main_valid;
    nxt_sv = skid_valid;
    nxt_md = main_data;
    nxt_sd = skid_data;
    if (!main_valid) begin
      // empty: payload goes straight to MAIN, skid bypassed
      if (in_fire) begin
        nxt_mv = 1'b1;
        nxt_md = in_data;
      end
    end else if (skid_valid) begin
      // two held: input blocked, drain MAIN and promote SKID
      if (out_fire) begin
        nxt_md = skid_data;
        nxt_sv = 1'b0;
        nxt_sd = NOP_DATA;
      end
    end else if (out_fire && in_fire) begin
      nxt_md = in_data;
    end else if (out_fire) begin
      nxt_mv = 1'b0;
      nxt_md = NOP_DATA;
    end else if (in_fire && SKID) begin
      nxt_sv = 1'b1;
      nxt_sd = in_data;
    end
  end

  // main_data is reloaded with NOP_DATA whenever MAIN empties, so out_data
  // can come straight off the flop and still be a bubble when invalid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= NOP_DATA;
      skid_data  <= NOP_DATA;
      cnt        <= 2'd0;
    end else begin
      main_valid <= nxt_mv;
      skid_valid <= nxt_sv;
      main_data  <= nxt_md;
      skid_data  <= nxt_sd;
      cnt        <= {1'b0, nxt_mv} + {1'b0, nxt_sv};
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign count     = cnt;

endmodule
